// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event arbiter.
// Round-robin selection is kept here so every user picks the same winner.
package btn_evt_pkg;

    localparam int MAX_BTN  = 8;
    localparam int MAX_ID_W = 3;
    localparam int DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // First set bit of mask after 'last', wrapping at n (n <= MAX_BTN).
    function automatic logic [MAX_ID_W-1:0] rr_next(
        input logic [MAX_BTN-1:0]  mask,
        input logic [MAX_ID_W-1:0] last,
        input int                  n
    );
        logic [MAX_ID_W-1:0] sel;
        logic [MAX_ID_W-1:0] jj;
        logic                hit;
        int                  j;
        sel = last;
        hit = 1'b0;
        for (int k = 1; k <= MAX_BTN; k++) begin
            j  = (int'(last) + k) % n;
            jj = j[MAX_ID_W-1:0];
            if (k <= n && !hit && mask[jj]) begin
                sel = jj;
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// One button: 2-flop synchroniser, debounce counter, one-cycle press pulse.
// The pulse is registered alongside the debounced level rise.
module btn_debounce_pulse
    import btn_evt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= s2;
                press <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounced buttons -> per-button pending flags -> round-robin grant
// -> first-word fall-through event FIFO drained by valid/ready.
module btn_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_BTN-1:0]           btn,
    output logic                       evt_valid,
    output logic [$clog2(N_BTN)-1:0]   evt_id,
    input  logic                       evt_ready,
    output logic [N_BTN-1:0]           btn_level,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       fifo_full
);

    localparam int ID_W  = $clog2(N_BTN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    logic [N_BTN-1:0]   press;
    logic [N_BTN-1:0]   pending;
    logic [N_BTN-1:0]   gnt_oh;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_v;
    logic               pop;
    logic [MAX_BTN-1:0] mask;
    logic [3:0]         n_drop;
    logic [DROP_W:0]    drop_sum;

    logic [ID_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce_pulse #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn[i]),
            .level(btn_level[i]),
            .press(press[i])
        );
    end

    assign evt_valid = (count != '0);
    assign fifo_full = (count == DEPTH_C);
    assign pop       = evt_valid & evt_ready;
    assign evt_id    = evt_valid ? mem[rd_ptr] : '0;

    // A pop frees a slot this very cycle, so a full FIFO can still accept.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_BTN; i++) mask[i] = pending[i];
        gnt_v   = (|pending) && (!fifo_full || pop);
        gnt_idx = ID_W'(rr_next(mask, MAX_ID_W'(last_grant), N_BTN));
        gnt_oh  = '0;
        if (gnt_v) gnt_oh[gnt_idx] = 1'b1;
        n_drop = '0;
        for (int i = 0; i < N_BTN; i++)
            n_drop = n_drop + 4'(press[i] & pending[i] & ~gnt_oh[i]);
        drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(n_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            drop_cnt   <= '0;
            last_grant <= ID_W'(N_BTN - 1);
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            pending  <= (pending & ~gnt_oh) | press;
            drop_cnt <= drop_sum[DROP_W] ? DROP_MAX : drop_sum[DROP_W-1:0];
            if (gnt_v) begin
                last_grant <= gnt_idx;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case (1'b1)
                (gnt_v & ~pop): count <= count + 1'b1;
                (pop & ~gnt_v): count <= count - 1'b1;
                default:        count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_v) mem[wr_ptr] <= gnt_idx;
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with DEBOUNCE_CYCLES=4, N_BTN=5,
// FIFO_DEPTH=4; expected values are hand-derived cycle by cycle.
module tb_btn_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    logic       evt_valid;
    logic [2:0] evt_id;
    logic       evt_ready;
    logic [4:0] btn_level;
    logic [7:0] drop_cnt;
    logic       fifo_full;

    int n_chk;
    int n_err;

    btn_event_arbiter #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_ready(evt_ready),
        .btn_level(btn_level),
        .drop_cnt (drop_cnt),
        .fifo_full(fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(evt_valid), 32'd0);
        check({tag, "_id"},    32'(evt_id),    32'd0);
        check({tag, "_level"}, 32'(btn_level), 32'd0);
        check({tag, "_drop"},  32'(drop_cnt),  32'd0);
        check({tag, "_full"},  32'(fifo_full), 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        btn       = '0;
        evt_ready = 1'b0;
        tick(2);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        // Single clean press of btn[2]: level at tick 6, event at tick 8 only.
        evt_ready = 1'b1;
        btn = 5'b00100;
        tick(6);
        check("a_level", 32'(btn_level), 32'b00100);
        tick();
        check("a_valid_early", 32'(evt_valid), 32'd0);
        tick();
        check("a_valid", 32'(evt_valid), 32'd1);
        check("a_id", 32'(evt_id), 32'd2);
        tick();
        check("a_valid_once", 32'(evt_valid), 32'd0);
        btn = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("a_release", 32'(evt_valid), 32'd0);
        end
        check("a_level_low", 32'(btn_level), 32'd0);

        // Bounce on btn[1] never stays stable for 4 samples.
        for (int i = 0; i < 30; i++) begin
            btn[1] = (i < 20) && ((i / 2) % 2 == 0);
            tick();
            check("b_level", 32'(btn_level[1]), 32'd0);
            check("b_valid", 32'(evt_valid), 32'd0);
        end

        // Simultaneous burst 0,3,4 from reset order, then 1,2 fills slot 4.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        evt_ready = 1'b0;
        btn       = 5'b11001;
        tick(12);
        check("c_valid", 32'(evt_valid), 32'd1);
        check("c_head", 32'(evt_id), 32'd0);
        check("c_not_full", 32'(fifo_full), 32'd0);
        btn = '0;
        tick(10);
        btn = 5'b00110;
        tick(12);
        check("c_full", 32'(fifo_full), 32'd1);
        check("c_head2", 32'(evt_id), 32'd0);
        btn = '0;
        tick(10);
        check("c_drop0", 32'(drop_cnt), 32'd0);

        // pending[2] already set: each further press is coalesced.
        for (int j = 1; j <= 3; j++) begin
            btn = 5'b00100;
            tick(8);
            btn = '0;
            tick(8);
            check("d_drop", 32'(drop_cnt), 32'(j));
            check("d_full", 32'(fifo_full), 32'd1);
        end

        // One-cycle pop while full: pending[2] pushed in the same edge.
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("e_full_kept", 32'(fifo_full), 32'd1);
        check("e_head", 32'(evt_id), 32'd3);
        tick(2);
        check("e_full_hold", 32'(fifo_full), 32'd1);
        check("e_head_hold", 32'(evt_id), 32'd3);
        evt_ready = 1'b1;
        check("e_drain0", 32'(evt_id), 32'd3);
        tick();
        check("e_drain1", 32'(evt_id), 32'd4);
        tick();
        check("e_drain2", 32'(evt_id), 32'd1);
        tick();
        check("e_drain3_valid", 32'(evt_valid), 32'd1);
        check("e_drain3", 32'(evt_id), 32'd2);
        tick();
        check("e_empty", 32'(evt_valid), 32'd0);
        tick(4);
        check("e_still_empty", 32'(evt_valid), 32'd0);
        check("e_drop", 32'(drop_cnt), 32'd3);

        // Reset mid-flight: 3 queued events, btn[4] held through reset.
        evt_ready = 1'b0;
        btn = 5'b10011;
        tick(12);
        check("f_valid", 32'(evt_valid), 32'd1);
        check("f_not_full", 32'(fifo_full), 32'd0);
        check("f_head", 32'(evt_id), 32'd4);
        btn = 5'b10000;
        tick(2);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("f_async");
        tick();
        check_idle_outputs("f_in_reset");
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("f_wait", 32'(evt_valid), 32'd0);
        end
        tick();
        check("f_evt_valid", 32'(evt_valid), 32'd1);
        check("f_evt_id", 32'(evt_id), 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("f_once", 32'(evt_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
